// File: rtl/out_port_bcd_display.sv
// out_port_bcd_display
//   Watches the CPU output port and shows its unsigned value as six decimal
//   digits on active-low 7-segment outputs hex5..hex0.
//   The binary-to-BCD conversion is sequential double-dabble, one shift-add-3
//   step per clock. All six digits load together at the end of a conversion.
//
//   Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//     defined   - zero digits above the most significant nonzero digit are
//                 blanked (7'h7F); hex0 always shows a digit; hex1..5 reset blank.
//     undefined - all six digits show, with leading zeros.
//
//   Handshake: there is no input handshake. A conversion starts whenever the
//   FSM is IDLE and out_port differs from the last captured value. Changes to
//   out_port during CONV/LOAD are ignored until the FSM returns to IDLE, where
//   out_port is compared again. 'busy' is high from capture until the hex
//   registers load, and 'update' pulses for exactly the one cycle after the
//   hex outputs take their new values.
module out_port_bcd_display #(
    parameter int IN_WIDTH  = 32,
    parameter int MAX_VALUE = 999999
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] out_port,
    output logic [6:0]          hex0,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2,
    output logic [6:0]          hex3,
    output logic [6:0]          hex4,
    output logic [6:0]          hex5,
    output logic                busy,
    output logic                update,
    output logic                overflow
);

    localparam int STEP_W = $clog2(IN_WIDTH + 1);
    localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(IN_WIDTH - 1);
    localparam logic [IN_WIDTH-1:0] MAX_VAL   = IN_WIDTH'(MAX_VALUE);

    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] LEAD_RESET = SEG_BLANK;
`else
    localparam logic [6:0] LEAD_RESET = SEG_ZERO;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IN_WIDTH-1:0] last;
    logic [IN_WIDTH-1:0] shift;
    logic [23:0]         bcd;
    logic [23:0]         bcd_adj;
    logic [STEP_W-1:0]   step;
    logic                ovf_q;
    logic                start;
    logic [6:0]          hex_q    [6];
    logic [6:0]          seg_next [6];

    // Active-low segment code for one BCD digit; anything above 9 shows a dash.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign start = (state == IDLE) && (out_port != last);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> CONV on a new value, CONV runs IN_WIDTH steps, LOAD for one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV;
            CONV:    if (step == LAST_STEP) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction for every BCD nibble that is 5 or more before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [5:0] lead_zero;

    // lead_zero[i] is set when digit i and every digit above it are zero.
    always_comb begin
        lead_zero    = '0;
        lead_zero[5] = (bcd[23:20] == 4'd0);
        for (int i = 4; i >= 1; i--) begin
            lead_zero[i] = lead_zero[i+1] && (bcd[4*i +: 4] == 4'd0);
        end
    end
`endif

    // Segment codes for the finished BCD value; overflow forces dashes, never blanked.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            seg_next[i] = ovf_q ? SEG_DASH : seg7(bcd[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (!ovf_q && (i > 0) && lead_zero[i]) begin
                seg_next[i] = SEG_BLANK;
            end
`endif
        end
    end

    // Datapath: capture, double-dabble steps, and the atomic load of all six digits.
    always_ff @(posedge clock) begin
        if (reset) begin
            last     <= '0;
            shift    <= '0;
            bcd      <= '0;
            step     <= '0;
            ovf_q    <= 1'b0;
            busy     <= 1'b0;
            update   <= 1'b0;
            overflow <= 1'b0;
            hex_q[0] <= SEG_ZERO;
            for (int i = 1; i < 6; i++) begin
                hex_q[i] <= LEAD_RESET;
            end
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift <= out_port;
                        last  <= out_port;
                        bcd   <= '0;
                        step  <= '0;
                        ovf_q <= (out_port > MAX_VAL);
                        busy  <= 1'b1;
                    end
                end
                CONV: begin
                    // Bits carried out of the top nibble are dropped; ovf_q already flags that case.
                    bcd   <= {bcd_adj[22:0], shift[IN_WIDTH-1]};
                    shift <= {shift[IN_WIDTH-2:0], 1'b0};
                    step  <= step + STEP_W'(1);
                end
                LOAD: begin
                    for (int i = 0; i < 6; i++) begin
                        hex_q[i] <= seg_next[i];
                    end
                    update   <= 1'b1;
                    busy     <= 1'b0;
                    overflow <= ovf_q;
                end
                default: ;
            endcase
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_out_port_bcd_display.sv
// tb_out_port_bcd_display
//   Directed scoreboard bench for out_port_bcd_display. Each driven value
//   pushes {expected update cycle, expected overflow, expected hex5..hex0}
//   into exp_q; a monitor pops and compares on every update pulse.
//   Honours LEADING_ZERO_BLANK_EN for the expected leading-digit code.
module tb_out_port_bcd_display;

    localparam int EXP_W = 75;   // {cycle[31:0], overflow, hex5..hex0}
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LD = 7'h7F;
`else
    localparam logic [6:0] LD = 7'h40;
`endif

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] out_port = '0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        busy, update, overflow;

    int cyc = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    out_port_bcd_display #(
        .IN_WIDTH (32),
        .MAX_VALUE(999999)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .out_port(out_port),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .hex4    (hex4),
        .hex5    (hex5),
        .busy    (busy),
        .update  (update),
        .overflow(overflow)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [41:0] hx(input logic [6:0] h5, input logic [6:0] h4,
                                       input logic [6:0] h3, input logic [6:0] h2,
                                       input logic [6:0] h1, input logic [6:0] h0);
        return {h5, h4, h3, h2, h1, h0};
    endfunction

    // Monitor: counts busy cycles and checks every update pulse against exp_q.
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end
            if (update) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: got update=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("hex5_hex0", {22'd0, hex5, hex4, hex3, hex2, hex1, hex0}, {22'd0, e[41:0]});
                    check("overflow", {63'd0, overflow}, {63'd0, e[42]});
                    check("update_cycle", 64'(cyc), {32'd0, e[74:43]});
                    check("busy_cycles", 64'(busy_cnt), 64'd33);
                    check("busy_low_at_update", {63'd0, busy}, 64'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive a new value at a negedge and queue the response expected 'lat' cycles later.
    task automatic apply(input logic [31:0] value, input logic [41:0] exp_hex,
                         input logic exp_ovf, input int lat);
        out_port = value;
        exp_q.push_back({32'(cyc + lat), exp_ovf, exp_hex});
    endtask

    // Queue an expectation without changing out_port (e.g. after a reset release).
    task automatic expect_only(input logic [41:0] exp_hex, input logic exp_ovf, input int lat);
        exp_q.push_back({32'(cyc + lat), exp_ovf, exp_hex});
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got pending=%0d expected 0 within 300 cycles", name, exp_q.size());
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_hex"}, {22'd0, hex5, hex4, hex3, hex2, hex1, hex0},
              {22'd0, hx(LD, LD, LD, LD, LD, 7'h40)});
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_update"}, {63'd0, update}, 64'd0);
        check({name, "_overflow"}, {63'd0, overflow}, 64'd0);
    endtask

    // Hard stop if anything hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        // 1: reset held 3 cycles with out_port = 0, then idle with no conversion.
        reset    = 1'b1;
        out_port = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset_held");
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check_reset_outputs("after_reset_zero");

        // 2: small value, leading digits zero or blank.
        apply(32'd3, hx(LD, LD, LD, LD, LD, 7'h30), 1'b0, 34);
        wait_idle("value_3");

        // 3: every digit distinct.
        apply(32'd123456, hx(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02), 1'b0, 34);
        wait_idle("value_123456");

        // 4: just over range shows dashes, then the largest in-range value clears overflow.
        apply(32'd1000000, hx(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), 1'b1, 34);
        wait_idle("value_1000000");
        apply(32'd999999, hx(7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10), 1'b0, 34);
        wait_idle("value_999999");

        // 5: change during a conversion is held off until the next IDLE.
        apply(32'd7, hx(LD, LD, LD, LD, LD, 7'h78), 1'b0, 34);
        repeat (10) @(negedge clock);
        apply(32'd42, hx(LD, LD, LD, LD, 7'h19, 7'h24), 1'b0, 58);
        wait_idle("value_7_then_42");

        // 6: reset at E15 aborts the conversion; the same value converts afresh after release.
        out_port = 32'd555555;
        repeat (15) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset_abort");
        reset = 1'b0;
        expect_only(hx(7'h12, 7'h12, 7'h12, 7'h12, 7'h12, 7'h12), 1'b0, 34);
        wait_idle("value_555555");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
